id_bypass_stage: RTL
====================

ID_BYPASS_STAGE -- requirements
Module: id_bypass_stage

Interface
REQ-001 Parameter DATA_W, default 32, register/forward data width.
REQ-002 Parameter RF_AW, default 5, register address width.
REQ-003 Parameter NUM_FWD, default 2, forwarding sources (index 0 = youngest/EX, highest priority).
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 stall  in  `StallBus  pipeline stall vector; bit1 = IF/ID, bit2 = ID/EX.
REQ-007 if_valid, if_pc  in  1, 32  fetch-stage valid and PC.
REQ-008 inst_sram_rdata  in  32  synchronous SRAM data, valid one cycle after fetch address.
REQ-009 fwd_we, fwd_waddr, fwd_wdata  in  NUM_FWD, NUM_FWD*RF_AW, NUM_FWD*DATA_W  packed bypass sources.
REQ-010 fwd_is_load  in  NUM_FWD  source holds a load whose data is not yet available.
REQ-011 rf_rdata1, rf_rdata2  in  DATA_W  register-file read data for rs/rt.
REQ-012 rs, rt  out  RF_AW  read addresses, driven from current instruction.
REQ-013 id_valid, id_pc, id_inst  out  1, 32, 32  decoded-stage content.
REQ-014 rs_val, rt_val  out  DATA_W  forwarded operands.
REQ-015 stallreq_for_load  out  1  load-use hazard request.

Function
REQ-016 Pipeline register update: stall[1]=Stop & stall[2]=NoStop -> load bubble (valid 0, pc 0); stall[1]=NoStop -> load if_valid/if_pc; else hold.
REQ-017 FSM states RUN, HOLD. RUN->HOLD on first cycle with stall[2]=Stop & id_valid; HOLD->RUN on stall[2]=NoStop.
REQ-018 On RUN->HOLD edge, inst_sram_rdata SHALL be captured into hold_inst; id_inst = hold_inst in HOLD, inst_sram_rdata in RUN.
REQ-019 Bubble load in any state SHALL force state RUN and id_inst = 0.
REQ-020 id_inst = 0 whenever id_valid = 0.
REQ-021 Operand select per rs/rt: lowest index i with fwd_we[i] & fwd_waddr[i]==addr & addr!=0 wins; else rf_rdata.
REQ-022 Address 0 SHALL always yield 0, never forwarded.
REQ-023 stallreq_for_load = id_valid & OR over matching i with fwd_is_load[i] (same match rule as REQ-021, rs or rt); combinational, same cycle.
REQ-024 A hit on a non-load younger source SHALL mask an older load match for that operand.
REQ-025 Forward and stall outputs are combinational from current state; zero added latency.
REQ-026 Simultaneous bubble and stall[2]=Stop: hold takes precedence only when stall[1]=Stop & stall[2]=Stop.

Reset
REQ-027 On rst: id_valid=0, id_pc=0, hold_inst=0, state=RUN; id_inst=0, stallreq_for_load=0 in the following cycle.
REQ-028 rst in HOLD SHALL discard hold_inst without writing outputs.

Configuration
REQ-029 Macro ID_BRANCH_RESOLVE_EN: when defined, adds output br_bus (`BR_WD: br_e, br_addr); beq/bne resolved on forwarded operands, br_addr = id_pc+4+(sext(imm)<<2).
REQ-030 br_e SHALL be 0 while stallreq_for_load=1 or id_valid=0.
REQ-031 Without macro, br_bus port and compare logic are absent; behaviour otherwise identical.

Structure
REQ-032 Shared package holds StallBus/Stop/NoStop, BR_WD, opcode constants (BEQ 6'h04, BNE 6'h05), FSM state encoding.
REQ-033 One sub-module fwd_mux (one operand, NUM_FWD-way priority select plus load-hit flag), instantiated twice.

Verification
REQ-034 EX writes r5=0x11, MEM writes r5=0x22, inst rs=5 -> rs_val=0x11.
REQ-035 EX load to r7 (fwd_is_load[0]=1), inst rt=7 -> stallreq_for_load=1; next cycle load cleared -> 0.
REQ-036 stall[2]=Stop for 3 cycles, SRAM data changes to 0xDEADBEEF -> id_inst stays at captured value, released on NoStop.
REQ-037 stall=6'b000010 -> id_valid=0, id_inst=0 next cycle.
REQ-038 fwd_waddr=0 with fwd_we=1, wdata 0xFFFF -> rs_val=0 for rs=0.
REQ-039 With ID_BRANCH_RESOLVE_EN: beq r1,r2, imm=0x0003, pc=0x1000, equal operands via forward -> br_e=1, br_addr=0x1010.

Source files
------------

// File: rtl/id_bypass_stage_pkg.sv
// Shared types and constants for the decode/bypass stage: stall vector,
// stop encoding, branch bus width, opcodes and FSM state encoding.
package id_bypass_stage_pkg;

  localparam int STALL_W = 6;
  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int BR_WD = 33;

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Branch target: pc + 4 + sign-extended word offset.
  function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/id_bypass_stage_if.sv
// Packed bypass-source bus from later pipeline stages (index 0 = youngest).
interface id_bypass_stage_if #(
  parameter int DATA_W  = 32,
  parameter int RF_AW   = 5,
  parameter int NUM_FWD = 2
);
  logic [NUM_FWD-1:0]        fwd_we;
  logic [NUM_FWD*RF_AW-1:0]  fwd_waddr;
  logic [NUM_FWD*DATA_W-1:0] fwd_wdata;
  logic [NUM_FWD-1:0]        fwd_is_load;

  modport master (output fwd_we, fwd_waddr, fwd_wdata, fwd_is_load);
  modport slave  (input  fwd_we, fwd_waddr, fwd_wdata, fwd_is_load);
endinterface

// File: rtl/id_bypass_stage_fwd_mux.sv
// One-operand priority bypass select; flags when the winning source is a
// load whose data is not yet available.
module fwd_mux #(
  parameter int DATA_W  = 32,
  parameter int RF_AW   = 5,
  parameter int NUM_FWD = 2
) (
  input  logic [RF_AW-1:0]          addr_i,
  input  logic [NUM_FWD-1:0]        fwd_we_i,
  input  logic [NUM_FWD*RF_AW-1:0]  fwd_waddr_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]        fwd_is_load_i,
  input  logic [DATA_W-1:0]         rf_rdata_i,
  output logic [DATA_W-1:0]         val_o,
  output logic                      load_hit_o
);

  logic hit_s;

  // Oldest source first so the youngest matching source overwrites last.
  always_comb begin
    val_o      = rf_rdata_i;
    load_hit_o = 1'b0;
    hit_s      = 1'b0;
    if (addr_i == {RF_AW{1'b0}}) begin
      val_o = {DATA_W{1'b0}};
    end else begin
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        hit_s      = fwd_we_i[i] && (fwd_waddr_i[i*RF_AW +: RF_AW] == addr_i);
        val_o      = hit_s ? fwd_wdata_i[i*DATA_W +: DATA_W] : val_o;
        load_hit_o = hit_s ? fwd_is_load_i[i] : load_hit_o;
      end
    end
  end

endmodule

// File: rtl/id_bypass_stage.sv
// IF/ID pipeline register with SRAM-instruction hold FSM and operand bypass.
// Optional branch resolution in decode is enabled by ID_BRANCH_RESOLVE_EN.
module id_bypass_stage
  import id_bypass_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RF_AW   = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  stall_bus_t          stall,
  input  logic                if_valid,
  input  logic [31:0]         if_pc,
  input  logic [31:0]         inst_sram_rdata,
  id_bypass_stage_if.slave    fwd,
  input  logic [DATA_W-1:0]   rf_rdata1,
  input  logic [DATA_W-1:0]   rf_rdata2,
  output logic [RF_AW-1:0]    rs,
  output logic [RF_AW-1:0]    rt,
  output logic                id_valid,
  output logic [31:0]         id_pc,
  output logic [31:0]         id_inst,
  output logic [DATA_W-1:0]   rs_val,
  output logic [DATA_W-1:0]   rt_val,
  output logic                stallreq_for_load
`ifdef ID_BRANCH_RESOLVE_EN
  ,
  output logic [BR_WD-1:0]    br_bus
`endif
);

  state_e      state_q, state_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic        bubble_s;
  logic        rs_load_s, rt_load_s;
  logic        unused_stall_s;

  assign unused_stall_s = ^{stall[5:3], stall[0]};
  assign bubble_s = (stall[1] == STOP) && (stall[2] == NO_STOP);

  always_comb begin
    id_valid_d  = id_valid_q;
    id_pc_d     = id_pc_q;
    hold_inst_d = hold_inst_q;
    state_d     = state_q;

    if (bubble_s) begin
      id_valid_d = 1'b0;
      id_pc_d    = 32'h0000_0000;
    end else if (stall[1] == NO_STOP) begin
      id_valid_d = if_valid;
      id_pc_d    = if_pc;
    end else begin
      id_valid_d = id_valid_q;
      id_pc_d    = id_pc_q;
    end

    // SRAM output moves on while decode is frozen, so snapshot it on entry to HOLD.
    case (state_q)
      ST_RUN: begin
        if ((stall[2] == STOP) && id_valid_q) begin
          state_d     = ST_HOLD;
          hold_inst_d = inst_sram_rdata;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (stall[2] == NO_STOP) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (bubble_s) begin
      state_d = ST_RUN;
    end else begin
      state_d = state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      id_valid_q  <= 1'b0;
      id_pc_q     <= 32'h0000_0000;
      hold_inst_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  always_comb begin
    id_inst = 32'h0000_0000;
    if (!id_valid_q) begin
      id_inst = 32'h0000_0000;
    end else if (state_q == ST_HOLD) begin
      id_inst = hold_inst_q;
    end else begin
      id_inst = inst_sram_rdata;
    end
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign rs       = id_inst[21 +: RF_AW];
  assign rt       = id_inst[16 +: RF_AW];

  fwd_mux #(.DATA_W(DATA_W), .RF_AW(RF_AW), .NUM_FWD(NUM_FWD)) u_fwd_rs (
    .addr_i        (rs),
    .fwd_we_i      (fwd.fwd_we),
    .fwd_waddr_i   (fwd.fwd_waddr),
    .fwd_wdata_i   (fwd.fwd_wdata),
    .fwd_is_load_i (fwd.fwd_is_load),
    .rf_rdata_i    (rf_rdata1),
    .val_o         (rs_val),
    .load_hit_o    (rs_load_s)
  );

  fwd_mux #(.DATA_W(DATA_W), .RF_AW(RF_AW), .NUM_FWD(NUM_FWD)) u_fwd_rt (
    .addr_i        (rt),
    .fwd_we_i      (fwd.fwd_we),
    .fwd_waddr_i   (fwd.fwd_waddr),
    .fwd_wdata_i   (fwd.fwd_wdata),
    .fwd_is_load_i (fwd.fwd_is_load),
    .rf_rdata_i    (rf_rdata2),
    .val_o         (rt_val),
    .load_hit_o    (rt_load_s)
  );

  assign stallreq_for_load = id_valid_q && (rs_load_s || rt_load_s);

`ifdef ID_BRANCH_RESOLVE_EN
  logic taken_s;

  always_comb begin
    taken_s = 1'b0;
    case (id_inst[31:26])
      OP_BEQ:  taken_s = (rs_val == rt_val);
      OP_BNE:  taken_s = (rs_val != rt_val);
      default: taken_s = 1'b0;
    endcase
  end

  assign br_bus = {id_valid_q && !stallreq_for_load && taken_s,
                   br_target(id_pc_q, id_inst[15:0])};
`endif

endmodule
